// File: rtl/vdp_super_fetch.sv
// VRAM word fetcher for the VDP_SUPER palette path: prefetches 32-bit words,
// replays repeated lines from a local buffer and unpacks 8/4/2 bpp indices.
module vdp_super_fetch #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned BUF_WORDS = 192,
  parameter int unsigned PF_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              h_active,
  input  logic              v_active,
  input  logic              disp_on,
  input  logic [1:0]        bpp_sel,
  input  logic              hscale,
  input  logic [1:0]        vrep,
  input  logic [7:0]        line_words,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        pal_hi,
  input  logic [7:0]        border_idx,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [31:0]       vram_data,
  output logic [7:0]        palette_addr,
  output logic              underflow
);

  localparam int unsigned PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(PF_DEPTH + 1);
  localparam int unsigned BW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam logic [CW-1:0] PF_FULL = CW'(PF_DEPTH);
  localparam logic [PW-1:0] PF_LAST = PW'(PF_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REPLAY} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]        r_bpp, r_vrep, r_rep;
  logic              r_hs, r_half, r_req, r_uflow, r_hact_d;
  logic [7:0]        r_lw, r_wleft, r_widx, r_rptr, r_used, r_pal_out;
  logic [5:0]        r_pal;
  logic [3:0]        r_pix;
  logic [ADDR_W-1:0] r_line_addr, r_fetch_addr;
  logic [31:0]       r_fifo [PF_DEPTH];
  logic [PW-1:0]     r_fwr, r_frd;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_lbuf [BUF_WORDS];

  logic              w_rst, w_win, w_line_end, w_ls, w_flush;
  logic [1:0]        w_rep_eff;
  logic [ADDR_W-1:0] w_line_addr_eff;
  logic              w_ack_ok, w_push_fetch, w_push_rep, w_push, w_req_set;
  logic [31:0]       w_push_data, w_head;
  logic              w_need, w_pix_ok, w_uflow, w_last, w_adv, w_pop;
  logic [7:0]        w_idx, w_out;

  assign w_rst      = reset | ~enable;
  assign w_win      = h_active & v_active;
  assign w_line_end = r_hact_d & ~h_active & (r_state != S_IDLE);
  assign w_ls       = line_start & v_active;
  assign w_flush    = w_line_end | w_ls;

  // frame_start takes precedence over a coincident line_start
  assign w_rep_eff       = frame_start ? 2'd0 : r_rep;
  assign w_line_addr_eff = frame_start ? base_addr : r_line_addr;

  // An ack landing on a flush cycle is taken but its word is dropped
  assign w_ack_ok     = vram_ack & r_req;
  assign w_push_fetch = w_ack_ok & (r_state == S_FETCH) & ~w_flush;
  assign w_push_rep   = (r_state == S_REPLAY) & (r_rptr != r_lw) & (r_cnt != PF_FULL) & ~w_flush;
  assign w_push       = w_push_fetch | w_push_rep;
  assign w_push_data  = (r_state == S_REPLAY) ? r_lbuf[r_rptr[BW-1:0]] : vram_data;
  assign w_req_set    = (r_state == S_FETCH) & ~r_req & (r_wleft != 8'd0) &
                        (r_cnt != PF_FULL) & ~w_flush;

  assign w_head   = r_fifo[r_frd];
  assign w_need   = w_win & (r_state != S_IDLE) & (r_used != r_lw);
  assign w_pix_ok = w_need & (r_cnt != '0);
  assign w_uflow  = w_need & (r_cnt == '0);
  assign w_adv    = w_pix_ok & (~r_hs | r_half);
  assign w_pop    = w_adv & w_last;

  always_comb begin
    w_idx  = '0;
    w_last = 1'b0;
    case (r_bpp)
      2'd1: begin
        w_idx  = {r_pal[5:2], w_head[{r_pix[2:0], 2'b00} +: 4]};
        w_last = (r_pix[2:0] == 3'd7);
      end
      2'd2: begin
        w_idx  = {r_pal, w_head[{r_pix, 1'b0} +: 2]};
        w_last = (r_pix == 4'd15);
      end
      default: begin
        w_idx  = w_head[{r_pix[1:0], 3'b000} +: 8];
        w_last = (r_pix[1:0] == 2'd3);
      end
    endcase
    w_out = border_idx;
    if (w_pix_ok) w_out = disp_on ? w_idx : 8'h00;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_line_end) w_state_nxt = S_IDLE;
    if (w_ls)       w_state_nxt = (w_rep_eff == 2'd0) ? S_FETCH : S_REPLAY;
  end

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Storage arrays carry no reset so the line buffer survives enable=0
  always_ff @(posedge clk) begin
    if (!w_rst && w_push_fetch) r_lbuf[r_widx[BW-1:0]] <= vram_data;
    if (!w_rst && w_push)       r_fifo[r_fwr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_bpp <= '0; r_vrep <= '0; r_rep <= '0; r_hs <= 1'b0; r_half <= 1'b0;
      r_req <= 1'b0; r_uflow <= 1'b0; r_hact_d <= 1'b0;
      r_lw <= '0; r_wleft <= '0; r_widx <= '0; r_rptr <= '0; r_used <= '0;
      r_pal <= '0; r_pix <= '0; r_line_addr <= '0; r_fetch_addr <= '0;
      r_fwr <= '0; r_frd <= '0; r_cnt <= '0;
      r_pal_out <= border_idx;
    end else begin
      r_hact_d  <= h_active;
      r_pal_out <= w_out;
      if (w_uflow) r_uflow <= 1'b1;

      if (w_line_end) begin
        if (r_rep == r_vrep) begin
          r_rep       <= 2'd0;
          r_line_addr <= r_line_addr + ADDR_W'(r_lw);
        end else begin
          r_rep <= r_rep + 2'd1;
        end
      end
      if (frame_start) begin
        r_line_addr <= base_addr;
        r_rep       <= 2'd0;
        r_uflow     <= 1'b0;
      end

      if (w_flush || w_ack_ok) r_req <= 1'b0;
      else if (w_req_set)      r_req <= 1'b1;

      if (w_push_fetch) begin
        r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        r_wleft      <= r_wleft - 8'd1;
        r_widx       <= r_widx + 8'd1;
      end
      if (w_push_rep) r_rptr <= r_rptr + 8'd1;

      if (w_push) r_fwr <= (r_fwr == PF_LAST) ? '0 : r_fwr + PW'(1);
      if (w_pop)  r_frd <= (r_frd == PF_LAST) ? '0 : r_frd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

      if (w_adv) begin
        r_half <= 1'b0;
        if (w_last) begin
          r_pix  <= '0;
          r_used <= r_used + 8'd1;
        end else begin
          r_pix <= r_pix + 4'd1;
        end
      end else if (w_pix_ok && r_hs) begin
        r_half <= 1'b1;
      end

      if (w_flush) begin
        r_fwr <= '0;
        r_frd <= '0;
        r_cnt <= '0;
      end

      if (w_ls) begin
        r_bpp  <= bpp_sel;
        r_hs   <= hscale;
        r_vrep <= vrep;
        r_lw   <= line_words;
        r_pal  <= pal_hi;
        r_pix  <= '0;
        r_half <= 1'b0;
        r_used <= '0;
        r_rptr <= '0;
        r_widx <= '0;
        r_wleft <= line_words;
        if (w_rep_eff == 2'd0) r_fetch_addr <= w_line_addr_eff;
      end
    end
  end

  assign vram_req     = r_req;
  assign vram_addr    = r_fetch_addr;
  assign palette_addr = r_pal_out;
  assign underflow    = r_uflow;

endmodule

// File: doc/vdp_super_fetch.md
Name: vdp_super_fetch

Overview:
- Parametrised successor to the fixed super-res/super-mid pixel fetcher. Converts 32-bit VRAM words into one 8-bit palette index per clock for the VDP_SUPER palette lookup.
- Selectable pixel depth: 8/4/2 bpp.
- Horizontal pixel doubling.
- Vertical line repeat 1..4 through an internal word line buffer.
- Word prefetch over a req/ack VRAM handshake.
- Sits between the VRAM arbiter and the palette RAM port (PALETTE_ADDR2 path).

Parameters:
- ADDR_W, 17, VRAM word-address width.
- BUF_WORDS, 192, line-buffer depth in 32-bit words; max words per source line.
- PF_DEPTH, 2, prefetch FIFO depth in words; must be at least 2.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  block enable; 0 behaves as reset except for the line buffer contents
- frame_start  in  1  one-cycle pulse; latches base_addr and clears the line-group counter
- line_start  in  1  one-cycle pulse; sent at least PF_DEPTH*4 clocks before the first h_active cycle of a line
- h_active  in  1  viewport pixel window for the current line
- v_active  in  1  viewport line window
- disp_on  in  1  0 forces pixel index 0 inside the window
- bpp_sel  in  2  0=8bpp (4 pix/word), 1=4bpp (8), 2=2bpp (16), 3=reserved (treated as 0)
- hscale  in  1  1 = each source pixel is output twice
- vrep  in  2  each source line is shown vrep+1 times
- line_words  in  8  words per source line, 1..BUF_WORDS
- base_addr  in  ADDR_W  frame start word address
- pal_hi  in  6  upper palette bits: 4bpp uses pal_hi[5:2]; 2bpp uses pal_hi[5:0]
- border_idx  in  8  index output outside the window or when pixels are exhausted
- vram_req  out  1  fetch request
- vram_addr  out  ADDR_W  request address; stable while vram_req=1
- vram_ack  in  1  one-cycle acknowledge; vram_data is valid in the same cycle
- vram_data  in  32  fetched word; pixel 0 = LSBs
- palette_addr  out  8  registered palette index
- underflow  out  1  sticky; cleared by frame_start

Behaviour:
- Reset / enable=0 values: vram_req=0, vram_addr=0, palette_addr=border_idx, underflow=0. Also cleared: FIFO, all counters, state=IDLE.
- Latching: line_addr<=base_addr and rep_cnt<=0 on frame_start.
- Line start, FSM IDLE -> FETCH or REPLAY:
  - FETCH when rep_cnt==0: fetch_addr<=line_addr, words_left<=line_words.
  - REPLAY otherwise: buffer read pointer<=0.
  - No transition when v_active=0.
- FETCH:
  - At most one outstanding request.
  - Assert vram_req when (FIFO occupancy + outstanding) < PF_DEPTH and words_left > 0.
  - On vram_ack: push vram_data to the FIFO, write it to line_buf[word_idx], fetch_addr+1 (wraps mod 2^ADDR_W), words_left-1.
- REPLAY:
  - FIFO is filled from line_buf at 1 word/clock under the same space rule.
  - No VRAM requests are issued.
- Unpacking (during h_active):
  - A pixel counter advances 1 per clock, or every 2nd clock when hscale=1.
  - A word is popped when its last pixel has been consumed.
  - Index: 8bpp byte; 4bpp {pal_hi[5:2],nibble}; 2bpp {pal_hi,crumb}. Lowest bits are first.
- Output timing:
  - palette_addr is registered.
  - The index for the pixel sampled at h_active cycle N appears at cycle N+1.
  - In that N+1 output: border_idx if h_active=0 or v_active=0; 0 if disp_on=0 (pixel stream still advances).
- Exhaustion: once all line_words words are consumed, border_idx is output for the rest of the window. This is not an underflow.
- Underflow: if a pixel is needed, the FIFO is empty and words remain, output border_idx, set underflow, and do not advance the counter.
- Line end (falling h_active), line-group bookkeeping:
  - rep_cnt<=(rep_cnt==vrep)?0:rep_cnt+1.
  - When wrapping to 0: line_addr<=line_addr+line_words, mod 2^ADDR_W.
- Line end (falling h_active), stream cleanup:
  - FIFO is flushed.
  - A pending outstanding ack is accepted and discarded.
  - vram_req drops.
  - FSM -> IDLE.
- Simultaneous events:
  - frame_start and line_start in the same cycle: frame_start applies first, so the line is FETCH from base_addr.
  - A line_start while not IDLE aborts the current line; no rep_cnt update.
- Configuration inputs: sampled at line_start only. Mid-line changes take effect at the next line.

Test Plan:
- 8bpp, hscale=0, vrep=0, line_words=2, words 0x04030201, 0x08070605, disp_on=1 -> palette_addr 01..08 on consecutive clocks starting h_active+1, then border_idx; vram_addr 0,1.
- 4bpp, pal_hi=0x28, word 0x000000BA -> first outputs 0xAA, 0xAB, then 0xA0 (pal_hi[5:2]=0xA); hscale=1 -> 0xAA,0xAA,0xAB,0xAB.
- 2bpp, vrep=2, base_addr=0x100, line_words=4 -> lines 0-2 identical; one set of 4 requests (0x100-0x103); line 3 fetches from 0x104.
- vram_ack withheld 10 clocks into the window -> border_idx output, underflow=1 until next frame_start, pixel index resumes without skipping.
- base_addr=0x1FFFF, line_words=2 -> requests 0x1FFFF then 0x00000.
- reset asserted mid-FETCH with vram_req=1 -> next cycle vram_req=0, palette_addr=border_idx, underflow=0.
